// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
// Holds the hazard-controller FSM state encoding and the hard-wired zero register index.
package mips_pkg;

  localparam logic       HZ_RUN      = 1'b0;
  localparam logic       HZ_MDU_BUSY = 1'b1;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  typedef enum logic {
    ST_RUN      = HZ_RUN,
    ST_MDU_BUSY = HZ_MDU_BUSY
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_mdu_timer.sv
// MDU occupancy timer: holds busy for LATENCY-1 cycles after a MULT/DIV issues.
// A start request is only honoured while idle; reset drops any in-flight operation.
module hz_mdu_timer
  import mips_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_busy
);

  localparam int            CW       = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and down-counter registers.
  always_ff @(posedge i_clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  // Next-state: load on issue, count down while busy, leave on the last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_reset) begin
      state_d = ST_RUN;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (i_start) begin
            state_d = ST_MDU_BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MDU_BUSY: begin
          if (cnt_q == CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  assign o_busy = (state_q == ST_MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use and HI/LO interlocks, taken-branch flush,
// pipeline enables and a saturating stall-cycle counter.
module hazard_ctrl_unit
  import mips_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int DELAY_SLOT  = 1,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_usesRs,
  input  logic             ID_usesRt,
  input  logic             ID_isMulDiv,
  input  logic             ID_readsHiLo,
  input  logic             ID_branchTaken,
  input  logic             EX_memRead,
  input  logic [4:0]       EX_rt,
  output logic             o_pcWrite,
  output logic             o_ifidWrite,
  output logic             o_ifidFlush,
  output logic             o_idexBubble,
  output logic             o_mduBusy,
  output logic [CNT_W-1:0] o_stallCount
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             FLUSH_ON_TAKEN = (DELAY_SLOT == 0);

  logic             load_use_s;
  logic             mdu_haz_s;
  logic             stall_s;
  logic             mdu_busy_s;
  logic             mdu_start_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Hazard detection; $zero is never a real dependency.
  always_comb begin
    load_use_s  = EX_memRead && (EX_rt != REG_ZERO) &&
                  ((ID_usesRs && (ID_rs == EX_rt)) || (ID_usesRt && (ID_rt == EX_rt)));
    mdu_haz_s   = mdu_busy_s && (ID_isMulDiv || ID_readsHiLo);
    stall_s     = load_use_s || mdu_haz_s;
    mdu_start_s = ID_isMulDiv && !stall_s && !i_reset;
  end

  hz_mdu_timer #(
    .LATENCY (MDU_LATENCY)
  ) u_mdu_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (mdu_start_s),
    .o_busy  (mdu_busy_s)
  );

  // Pipeline controls; a stall suppresses the branch flush so the branch re-resolves later.
  always_comb begin
    o_pcWrite    = 1'b1;
    o_ifidWrite  = 1'b1;
    o_ifidFlush  = 1'b0;
    o_idexBubble = 1'b0;
    o_mduBusy    = mdu_busy_s;
    if (i_reset) begin
      o_pcWrite    = 1'b0;
      o_ifidWrite  = 1'b0;
      o_ifidFlush  = 1'b1;
      o_idexBubble = 1'b1;
      o_mduBusy    = 1'b0;
    end else if (stall_s) begin
      o_pcWrite    = 1'b0;
      o_ifidWrite  = 1'b0;
      o_idexBubble = 1'b1;
      o_ifidFlush  = 1'b0;
    end else begin
      o_ifidFlush = ID_branchTaken && FLUSH_ON_TAKEN;
    end
  end

  // Saturating stall counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_reset) begin
      stall_cnt_d = CNT_ZERO;
    end else if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign o_stallCount = stall_cnt_q;

endmodule
